// File: rtl/mul_div_unit_if.sv
// Execute-stage MDU bus: operands and opcode in, HI/LO/read data and busy out.
// Latency: none by itself; the bundle carries the signals only.
// Backpressure: busy is the only flow control; a start seen while busy is dropped.
//
// Signals:
//   start      EX instruction valid for mdu_op this cycle
//   cancel     flush of the EX instruction, suppresses start this cycle
//   mdu_op     4-bit MDU opcode (1 MULT .. 8 MFLO)
//   input1/2   rs/rt forwarded operands
//   busy       multiply/divide in flight
//   hi/lo      architectural HI/LO
//   read_data  MFHI/MFLO read value, 0 for other ops
interface mul_div_unit_if;
  logic        start;
  logic        cancel;
  logic [3:0]  mdu_op;
  logic [31:0] input1;
  logic [31:0] input2;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] read_data;

  // Pipeline side: issues operations and observes results.
  modport master (
    output start, cancel, mdu_op, input1, input2,
    input  busy, hi, lo, read_data
  );

  // Unit side.
  modport slave (
    input  start, cancel, mdu_op, input1, input2,
    output busy, hi, lo, read_data
  );
endinterface

// File: rtl/mul_div_unit.sv
// Multiply/divide unit with architectural HI/LO; MTHI/MTLO writes, MFHI/MFLO reads.
// Latency: MULT/MULTU busy MULT_CYCLES, DIV/DIVU busy DIV_CYCLES, MT one edge, MF combinational.
// Backpressure: busy stalls following MDU decode; any start seen while running is ignored.
//
// Ports:
//   i_clk    rising-edge clock
//   i_reset  asynchronous active-low reset (0 = reset)
//   bus      mul_div_unit_if.slave (start/cancel/mdu_op/input1/input2 in,
//            busy/hi/lo/read_data out)
module mul_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic           i_clk,
  input  logic           i_reset,
  mul_div_unit_if.slave  bus
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_pend_hi;
  logic [31:0]      r_pend_lo;

  logic [31:0] w_a;
  logic [31:0] w_b;
  logic        w_go;
  logic [63:0] w_a_sext;
  logic [63:0] w_b_sext;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_b_nz;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_div_b;
  logic [31:0] w_mag_b;
  logic [31:0] w_sq_mag;
  logic [31:0] w_sr_mag;
  logic [31:0] w_sdiv_q;
  logic [31:0] w_sdiv_r;
  logic [31:0] w_udiv_q;
  logic [31:0] w_udiv_r;
  logic [31:0] w_pend_hi;
  logic [31:0] w_pend_lo;
  logic        w_long_op;

  assign w_a  = bus.input1;
  assign w_b  = bus.input2;
  assign w_go = bus.start & ~bus.cancel & (r_state == S_IDLE);

  // 64x64 products truncated to 64 bits hold the exact 32x32 result.
  assign w_a_sext = {{32{w_a[31]}}, w_a};
  assign w_b_sext = {{32{w_b[31]}}, w_b};
  assign w_prod_s = $signed(w_a_sext) * $signed(w_b_sext);
  assign w_prod_u = {32'd0, w_a} * {32'd0, w_b};

  // Signed divide on magnitudes; sidesteps the INT_MIN / -1 overflow case
  // because |INT_MIN| fits in 32 unsigned bits and the signs cancel.
  assign w_b_nz  = (w_b != 32'd0);
  assign w_a_mag = w_a[31] ? (~w_a + 32'd1) : w_a;
  assign w_b_mag = w_b[31] ? (~w_b + 32'd1) : w_b;
  // Substitute divisor 1 on divide-by-zero so no X/undefined math reaches pend.
  assign w_div_b = w_b_nz ? w_b : 32'd1;
  assign w_mag_b = w_b_nz ? w_b_mag : 32'd1;

  assign w_sq_mag = w_a_mag / w_mag_b;
  assign w_sr_mag = w_a_mag % w_mag_b;
  assign w_sdiv_q = (w_a[31] ^ w_b[31]) ? (~w_sq_mag + 32'd1) : w_sq_mag;
  assign w_sdiv_r = w_a[31] ? (~w_sr_mag + 32'd1) : w_sr_mag;
  assign w_udiv_q = w_a / w_div_b;
  assign w_udiv_r = w_a % w_div_b;

  assign w_long_op = (bus.mdu_op == OP_MULT) || (bus.mdu_op == OP_MULTU) ||
                     (bus.mdu_op == OP_DIV)  || (bus.mdu_op == OP_DIVU);

  // Result staged at accept; divide-by-zero stages the current HI/LO so
  // the commit leaves them unchanged.
  always_comb begin
    w_pend_hi = r_hi;
    w_pend_lo = r_lo;
    case (bus.mdu_op)
      OP_MULT: begin
        w_pend_hi = w_prod_s[63:32];
        w_pend_lo = w_prod_s[31:0];
      end
      OP_MULTU: begin
        w_pend_hi = w_prod_u[63:32];
        w_pend_lo = w_prod_u[31:0];
      end
      OP_DIV: begin
        if (w_b_nz) begin
          w_pend_hi = w_sdiv_r;
          w_pend_lo = w_sdiv_q;
        end
      end
      OP_DIVU: begin
        if (w_b_nz) begin
          w_pend_hi = w_udiv_r;
          w_pend_lo = w_udiv_q;
        end
      end
      default: begin
        w_pend_hi = r_hi;
        w_pend_lo = r_lo;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            if (w_long_op) begin
              r_pend_hi <= w_pend_hi;
              r_pend_lo <= w_pend_lo;
              r_state   <= S_RUN;
              if ((bus.mdu_op == OP_MULT) || (bus.mdu_op == OP_MULTU)) begin
                r_cnt <= CNT_W'(MULT_CYCLES);
              end else begin
                r_cnt <= CNT_W'(DIV_CYCLES);
              end
            end else if (bus.mdu_op == OP_MTHI) begin
              r_hi <= w_a;
            end else if (bus.mdu_op == OP_MTLO) begin
              r_lo <= w_a;
            end
          end
        end
        default: begin
          // Running: starts are ignored; cancel cannot abort.
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_hi    <= r_pend_hi;
            r_lo    <= r_pend_lo;
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy = (r_state == S_RUN);
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

  assign bus.read_data = (bus.mdu_op == OP_MFHI) ? r_hi :
                         (bus.mdu_op == OP_MFLO) ? r_lo : 32'd0;

endmodule
